mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit of the MEM stage, directly downstream of the ALU.
- Takes the ALU result as the effective address (or as the pass-through value for non-memory ops), plus rs2 store data and funct3.
- Drives a single-outstanding-request data-memory port with variable wait states.
- Returns the sign/zero-extended load data, or the passed-through ALU result, to writeback through a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, width of alu_result and dmem_addr; data width is fixed at 32.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX stage presents an op
- in_ready  out  1  LSU can accept an op this cycle
- alu_result  in  ADDR_WIDTH  effective address / pass-through value
- rs2_data  in  32  store data
- mem_read  in  1  op is a load
- mem_write  in  1  op is a store
- funct3  in  3  access size/sign (RV32I encoding)
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid with dmem_ack
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts the result
- out_data  out  32  load data or pass-through alu_result (zero-extended to 32)
- misalign  out  1  accompanies out_valid when the access was misaligned; 0 when MISALIGN_TRAP_EN is undefined

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; in_ready=1, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, out_valid=0, out_data=0, misalign=0.
- States: IDLE, WAIT_ACK, HOLD.
- IDLE:
  - in_ready=1. An op is accepted when in_valid & in_ready.
  - Non-memory op (mem_read=mem_write=0): out_data<=alu_result, go to HOLD; out_valid is high the next cycle (latency 1).
  - Memory op: register address, size and sign; drive dmem_req=1 the next cycle; go to WAIT_ACK.
  - mem_read and mem_write both set: treated as a store.
- WAIT_ACK:
  - in_ready=0; dmem_req and all dmem_* outputs held stable until dmem_ack.
  - On dmem_ack: dmem_req<=0; out_data<=formatted result; go to HOLD.
  - Ack in the first request cycle gives out_valid 2 cycles after accept.
  - Each extra wait state adds 1 cycle.
- HOLD:
  - out_valid=1 with out_data and misalign stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid low next cycle.
  - in_ready=0 in HOLD, so there is no accept in the same cycle as the handoff. Throughput is at most 1 op per 2 cycles.
- Store formatting, with off = addr[1:0]:
  - SB (000): wdata = byte replicated x4, wstrb = 1<<off.
  - SH (001): wdata = half replicated x2, wstrb = 0011<<off (off in {0,2}).
  - SW (010): wdata = rs2_data, wstrb = 1111.
  - Stores return out_data = 0.
- Load formatting:
  - Select byte/half from dmem_rdata by off.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) returns the full word.
- Undefined funct3: loads behave as LW, stores as SW.
- dmem_ack outside WAIT_ACK is ignored.
- Reset mid-operation (any state): immediate return to reset values at the next edge. The pending request is abandoned, and a late ack is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (half with addr[0]=1, word with addr[1:0]!=0) issues no memory request.
  - Goes straight from accept to HOLD with out_valid next cycle, misalign=1, out_data=alu_result (faulting address).
- Undefined:
  - No check is made; misalign is tied to 0.
  - Offset bits are masked: word ignores addr[1:0], half ignores addr[0]. The access proceeds normally.

Test Plan:
- Pass-through: alu_result=0x3600000e, mem_read=mem_write=0 -> out_valid 1 cycle after accept, out_data=0x3600000e, dmem_req never asserted.
- LB sign: addr=0x000000ef, dmem_rdata=0x80FF7F01, ack after 3 wait cycles -> dmem_addr=0x000000ec, out_data=0xFFFFFF80, dmem_req held 4 cycles.
- LHU: addr=0x0000a002, rdata=0xBEEF1234, immediate ack -> out_data=0x0000BEEF, out_valid 2 cycles after accept.
- SB at off 1: addr=0x10000001, rs2=0x000000AB -> dmem_we=1, wdata=0xABABABAB, wstrb=0010; SH at off 2, rs2=0x1234 -> wdata=0x12341234, wstrb=1100.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0; assert rst during WAIT_ACK, then ack -> all outputs at reset values, no out_valid.
- MISALIGN_TRAP_EN defined: LW at 0x08000002 -> no dmem_req, misalign=1, out_data=0x08000002. Undefined: dmem_addr=0x08000000, misalign=0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// MEM-stage LSU bus: EX handoff, data-memory port, writeback handoff.
// slave = LSU side, master = environment (EX / memory / WB) side.
interface mem_stage_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] alu_result;
  logic [31:0]           rs2_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [3:0]            dmem_wstrb;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic                  misalign;

  modport slave (
    input  in_valid, alu_result, rs2_data,
    input  mem_read, mem_write, funct3,
    input  dmem_ack, dmem_rdata, out_ready,
    output in_ready, dmem_req, dmem_we,
    output dmem_addr, dmem_wdata, dmem_wstrb,
    output out_valid, out_data, misalign
  );

  modport master (
    output in_valid, alu_result, rs2_data,
    output mem_read, mem_write, funct3,
    output dmem_ack, dmem_rdata, out_ready,
    input  in_ready, dmem_req, dmem_we,
    input  dmem_addr, dmem_wdata, dmem_wstrb,
    input  out_valid, out_data, misalign
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding dmem request, formatted
// load data or ALU pass-through to WB over valid/ready.
// Ports: clk, rst (sync, active high), bus (mem_stage_lsu_if.slave).
// Option: MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mem_stage_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_out_data;
`ifdef MISALIGN_TRAP_EN
  logic                  r_misalign;
`endif

  logic        w_req;
  logic        w_mem;
  logic        w_store;
  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic [1:0]  w_araw;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_rsh;
  logic [31:0] w_load;
  logic        w_sgn;

  // Access size: stores only honour exact SB/SH codes, loads ignore
  // the unsigned bit; everything else is a word access.
  assign w_mem   = bus.mem_read | bus.mem_write;
  assign w_store = bus.mem_write;
  assign w_byte  = w_store ? (bus.funct3 == 3'b000)
                           : (bus.funct3[1:0] == 2'b00);
  assign w_half  = w_store ? (bus.funct3 == 3'b001)
                           : (bus.funct3[1:0] == 2'b01);
  assign w_word  = ~w_byte & ~w_half;
  assign w_araw  = bus.alu_result[1:0];

  assign w_off = w_word ? 2'b00 :
                 w_half ? {w_araw[1], 1'b0} :
                 w_araw;

`ifdef MISALIGN_TRAP_EN
  assign w_mis = w_mem &
                 ((w_half & w_araw[0]) |
                  (w_word & (w_araw != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_wdata = 32'h0;
    w_wstrb = 4'h0;
    if (w_store) begin
      unique case (1'b1)
        w_byte: begin
          w_wdata = {4{bus.rs2_data[7:0]}};
          w_wstrb = 4'b0001 << w_off;
        end
        w_half: begin
          w_wdata = {2{bus.rs2_data[15:0]}};
          w_wstrb = 4'b0011 << w_off;
        end
        default: begin
          w_wdata = bus.rs2_data;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign w_rsh = bus.dmem_rdata >> {r_off, 3'b000};
  assign w_sgn = ~r_f3[2];

  always_comb begin
    w_load = bus.dmem_rdata;
    unique case (1'b1)
      (r_f3[1:0] == 2'b00):
        w_load = {{24{w_sgn & w_rsh[7]}}, w_rsh[7:0]};
      (r_f3[1:0] == 2'b01):
        w_load = {{16{w_sgn & w_rsh[15]}}, w_rsh[15:0]};
      default:
        w_load = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.in_valid)
          w_next = (w_mem & ~w_mis) ? S_WAIT : S_HOLD;
      S_WAIT:
        if (bus.dmem_ack) w_next = S_HOLD;
      S_HOLD:
        if (bus.out_ready) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req          = (r_state == S_WAIT);
    bus.in_ready   = (r_state == S_IDLE);
    bus.dmem_req   = w_req;
    bus.dmem_we    = w_req & r_we;
    bus.dmem_addr  = w_req ? r_addr : '0;
    bus.dmem_wdata = w_req ? r_wdata : 32'h0;
    bus.dmem_wstrb = w_req ? r_wstrb : 4'h0;
    bus.out_valid  = (r_state == S_HOLD);
    bus.out_data   = r_out_data;
`ifdef MISALIGN_TRAP_EN
    bus.misalign   = r_misalign;
`else
    bus.misalign   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      r_we       <= 1'b0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_out_data <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_addr  <= {bus.alu_result[ADDR_WIDTH-1:2], 2'b00};
          r_f3    <= bus.funct3;
          r_off   <= w_off;
          r_we    <= w_store;
          r_wdata <= w_wdata;
          r_wstrb <= w_wstrb;
          // Pass-through and trapped ops report alu_result directly.
          if (~w_mem | w_mis)
            r_out_data <= 32'(bus.alu_result);
`ifdef MISALIGN_TRAP_EN
          r_misalign <= w_mis;
`endif
        end
        S_WAIT: if (bus.dmem_ack)
          r_out_data <= r_we ? 32'h0 : w_load;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed table-driven bench for mem_stage_lsu plus backpressure,
// stray-ack and mid-request reset sequences.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_WIDTH(32)) bus();

  mem_stage_lsu #(.ADDR_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] rs2;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          waits;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string n, input logic [31:0] a, input logic [31:0] rs2,
    input logic rd, input logic wr, input logic [2:0] f3,
    input logic [31:0] rdata, input int waits, input logic req,
    input logic [31:0] addr, input logic we, input logic [31:0] wdata,
    input logic [3:0] strb, input logic [31:0] data, input logic mis);
    vec_t v;
    v.name = n; v.a = a; v.rs2 = rs2; v.rd = rd; v.wr = wr;
    v.f3 = f3; v.rdata = rdata; v.waits = waits; v.req = req;
    v.addr = addr; v.we = we; v.wdata = wdata; v.strb = strb;
    v.data = data; v.mis = mis;
    return v;
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] rs2,
                          input logic rd, input logic wr,
                          input logic [2:0] f3);
    bus.in_valid   = 1'b1;
    bus.alu_result = a;
    bus.rs2_data   = rs2;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
  endtask

  task automatic idle_in();
    bus.in_valid  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.rs2_data  = 32'h0;
  endtask

  task automatic check_reset_vals(input string n);
    chk({n, " in_ready"}, bus.in_ready, 1);
    chk({n, " dmem_req"}, bus.dmem_req, 0);
    chk({n, " dmem_we"}, bus.dmem_we, 0);
    chk({n, " dmem_addr"}, bus.dmem_addr, 0);
    chk({n, " dmem_wdata"}, bus.dmem_wdata, 0);
    chk({n, " dmem_wstrb"}, bus.dmem_wstrb, 0);
    chk({n, " out_valid"}, bus.out_valid, 0);
    chk({n, " out_data"}, bus.out_data, 0);
    chk({n, " misalign"}, bus.misalign, 0);
  endtask

  task automatic run(input vec_t v);
    int reqc;
    @(negedge clk);
    chk({v.name, " in_ready"}, bus.in_ready, 1);
    drive_op(v.a, v.rs2, v.rd, v.wr, v.f3);
    @(negedge clk);
    idle_in();
    if (v.req) begin
      reqc = 0;
      chk({v.name, " addr"}, bus.dmem_addr, v.addr);
      chk({v.name, " we"}, bus.dmem_we, v.we);
      chk({v.name, " wdata"}, bus.dmem_wdata, v.wdata);
      chk({v.name, " wstrb"}, bus.dmem_wstrb, v.strb);
      chk({v.name, " busy"}, bus.in_ready, 0);
      for (int i = 0; i < v.waits; i++) begin
        if (bus.dmem_req) reqc++;
        chk({v.name, " early valid"}, bus.out_valid, 0);
        @(negedge clk);
        chk({v.name, " addr held"}, bus.dmem_addr, v.addr);
        chk({v.name, " wdata held"}, bus.dmem_wdata, v.wdata);
      end
      if (bus.dmem_req) reqc++;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = v.rdata;
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'hDEAD_0000;
      chk({v.name, " req cycles"}, reqc, v.waits + 1);
      chk({v.name, " req drop"}, bus.dmem_req, 0);
    end else begin
      chk({v.name, " no req"}, bus.dmem_req, 0);
    end
    chk({v.name, " out_valid"}, bus.out_valid, 1);
    chk({v.name, " out_data"}, bus.out_data, v.data);
    chk({v.name, " misalign"}, bus.misalign, v.mis);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({v.name, " valid drop"}, bus.out_valid, 0);
    chk({v.name, " ready back"}, bus.in_ready, 1);
  endtask

  initial begin
    idle_in();
    bus.alu_result = 32'h0;
    bus.funct3     = 3'b000;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    bus.out_ready  = 1'b0;

    tv.push_back(mk("pass", 32'h3600000e, 0, 0, 0, 3'b000, 0, 0,
      0, 0, 0, 0, 4'h0, 32'h3600000e, 0));
    tv.push_back(mk("lb_sign", 32'h000000ef, 0, 1, 0, 3'b000,
      32'h80FF7F01, 3, 1, 32'h000000ec, 0, 0, 4'h0, 32'hFFFFFF80, 0));
    tv.push_back(mk("lb_off2", 32'h00000012, 0, 1, 0, 3'b000,
      32'h80FF7F01, 0, 1, 32'h00000010, 0, 0, 4'h0, 32'hFFFFFFFF, 0));
    tv.push_back(mk("lhu", 32'h0000a002, 0, 1, 0, 3'b101,
      32'hBEEF1234, 0, 1, 32'h0000a000, 0, 0, 4'h0, 32'h0000BEEF, 0));
    tv.push_back(mk("lh_sign", 32'h00000100, 0, 1, 0, 3'b001,
      32'h00008001, 2, 1, 32'h00000100, 0, 0, 4'h0, 32'hFFFF8001, 0));
    tv.push_back(mk("lbu", 32'h00000102, 0, 1, 0, 3'b100,
      32'h12C35678, 0, 1, 32'h00000100, 0, 0, 4'h0, 32'h000000C3, 0));
    tv.push_back(mk("lw", 32'h00000200, 0, 1, 0, 3'b010,
      32'hCAFEBABE, 1, 1, 32'h00000200, 0, 0, 4'h0, 32'hCAFEBABE, 0));
    tv.push_back(mk("ld_f3_011", 32'h00000204, 0, 1, 0, 3'b011,
      32'h01234567, 0, 1, 32'h00000204, 0, 0, 4'h0, 32'h01234567, 0));
    tv.push_back(mk("sb_off1", 32'h10000001, 32'h000000AB, 0, 1,
      3'b000, 0, 0, 1, 32'h10000000, 1, 32'hABABABAB, 4'b0010, 0, 0));
    tv.push_back(mk("sh_off2", 32'h10000002, 32'h00001234, 0, 1,
      3'b001, 0, 1, 1, 32'h10000000, 1, 32'h12341234, 4'b1100, 0, 0));
    tv.push_back(mk("sw", 32'h20000004, 32'hDEADBEEF, 0, 1, 3'b010,
      0, 2, 1, 32'h20000004, 1, 32'hDEADBEEF, 4'b1111, 0, 0));
    tv.push_back(mk("rd_wr_sb", 32'h00000003, 32'h0000005A, 1, 1,
      3'b000, 32'hFFFFFFFF, 0, 1, 0, 1, 32'h5A5A5A5A, 4'b1000, 0, 0));
    tv.push_back(mk("st_f3_111", 32'h00000008, 32'h11223344, 0, 1,
      3'b111, 0, 0, 1, 32'h00000008, 1, 32'h11223344, 4'b1111, 0, 0));
`ifdef MISALIGN_TRAP_EN
    tv.push_back(mk("lw_mis", 32'h08000002, 0, 1, 0, 3'b010, 0, 0,
      0, 0, 0, 0, 4'h0, 32'h08000002, 1));
    tv.push_back(mk("lh_mis", 32'h00000301, 0, 1, 0, 3'b001, 0, 0,
      0, 0, 0, 0, 4'h0, 32'h00000301, 1));
    tv.push_back(mk("sh_mis", 32'h10000003, 32'h0000BEEF, 0, 1,
      3'b001, 0, 0, 0, 0, 0, 0, 4'h0, 32'h10000003, 1));
`else
    tv.push_back(mk("lw_mis", 32'h08000002, 0, 1, 0, 3'b010,
      32'h55AA55AA, 0, 1, 32'h08000000, 0, 0, 4'h0, 32'h55AA55AA, 0));
    tv.push_back(mk("lh_mis", 32'h00000301, 0, 1, 0, 3'b001,
      32'hAAAA7FFF, 0, 1, 32'h00000300, 0, 0, 4'h0, 32'h00007FFF, 0));
    tv.push_back(mk("sh_mis", 32'h10000003, 32'h0000BEEF, 0, 1,
      3'b001, 0, 0, 1, 32'h10000000, 1, 32'hBEEFBEEF, 4'b1100, 0, 0));
`endif

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    foreach (tv[i]) run(tv[i]);

    // Backpressure with a stray ack and an ignored in_valid in HOLD.
    @(negedge clk);
    drive_op(32'h00000040, 0, 1, 0, 3'b010);
    @(negedge clk);
    idle_in();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h13579BDF;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    drive_op(32'h77777777, 0, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      bus.dmem_ack   = (i == 2);
      bus.dmem_rdata = 32'h0BAD0BAD;
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp out_data", bus.out_data, 32'h13579BDF);
      chk("bp in_ready", bus.in_ready, 0);
      chk("bp dmem_req", bus.dmem_req, 0);
      @(negedge clk);
    end
    bus.dmem_ack = 1'b0;
    idle_in();
    chk("bp still held", bus.out_data, 32'h13579BDF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp release", bus.out_valid, 0);
    chk("bp no extra req", bus.dmem_req, 0);

    // Reset while waiting for ack, then a late ack.
    @(negedge clk);
    drive_op(32'h00000080, 32'hFFFFFFFF, 0, 1, 3'b010);
    @(negedge clk);
    idle_in();
    chk("rst pre req", bus.dmem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h89ABCDEF;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check_reset_vals("mid rst");
    @(negedge clk);
    chk("mid rst no valid", bus.out_valid, 0);
    chk("mid rst no req", bus.dmem_req, 0);

    run(tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
